// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central sequencer for the 5-stage pipeline's stage-register enables and
// flushes. Four hold/flush sources are merged into one consistent per-stage
// control set by fixed priority: data-memory wait, taken branch, MDU start,
// load-use hazard. Control outputs are Mealy (state + current inputs), so
// they act in the same cycle the event is signalled.
//
// Parameters:
//   BRANCH_PENALTY  total cycles IF/ID is flushed after a taken branch (1..7)
//   MDU_TIMEOUT     max cycles spent in MDU_WAIT before forced exit (2..1023)
//   CNT_W           width of the stall-cycle performance counter
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   load_use_hazard                  ID instruction depends on a load in EXE
//   branch_taken                     EXE resolved a taken branch this cycle
//   mdu_start / mdu_done             MDU op entering EXE / MDU result valid
//   dmem_wait                        data memory not ready, MEM must hold
//   stat_clr                         synchronous clear of stall_cycles
//   pc_write_en, *_write_en          stage register load enables
//   if_id_flush, id_exe_flush,
//   exe_mem_flush                    stage register loads NOP/bubble
//   mdu_timeout                      one-cycle registered pulse on MDU timeout
//   stall_cycles                     saturating count of cycles with PC held
// -----------------------------------------------------------------------------
module pipeline_stall_controller #(
  parameter int BRANCH_PENALTY = 2,
  parameter int MDU_TIMEOUT    = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_hazard,
  input  logic             branch_taken,
  input  logic             mdu_start,
  input  logic             mdu_done,
  input  logic             dmem_wait,
  input  logic             stat_clr,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_exe_write_en,
  output logic             id_exe_flush,
  output logic             exe_mem_write_en,
  output logic             exe_mem_flush,
  output logic             mem_wb_write_en,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int                WAIT_W     = $clog2(MDU_TIMEOUT);
  localparam logic [2:0]        FLUSH_INIT = 3'(BRANCH_PENALTY - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MDU_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MDU_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        flush_cnt_q, flush_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_fire;

  // Un-gated control set; gated with rst_n below so everything is quiet in reset.
  logic pc_we, if_id_we, if_id_fl, id_exe_we, id_exe_fl;
  logic exe_mem_we, exe_mem_fl, mem_wb_we;

  // NOTE: every signal written here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_fire = 1'b0;
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_fl     = 1'b0;
    id_exe_we    = 1'b1;
    id_exe_fl    = 1'b0;
    exe_mem_we   = 1'b1;
    exe_mem_fl   = 1'b0;
    mem_wb_we    = 1'b1;

    if (dmem_wait) begin
      // Whole pipe freezes; FSM and counters hold, all other events ignored.
      pc_we      = 1'b0;
      if_id_we   = 1'b0;
      id_exe_we  = 1'b0;
      exe_mem_we = 1'b0;
      mem_wb_we  = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (branch_taken) begin
            // Squashes the wrong-path IF and ID instructions, including any
            // MDU op or load-use consumer sitting behind the branch.
            if_id_fl  = 1'b1;
            id_exe_fl = 1'b1;
            if (BRANCH_PENALTY > 1) begin
              state_d     = FLUSH;
              flush_cnt_d = FLUSH_INIT;
            end
          end else if (mdu_start) begin
            state_d    = MDU_WAIT;
            wait_cnt_d = '0;
          end else if (load_use_hazard) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_exe_fl = 1'b1;
          end
        end

        FLUSH: begin
          if_id_fl = 1'b1;
          // flush_cnt counts the FLUSH cycles still to run, including this one.
          if (flush_cnt_q <= 3'd1) begin
            state_d     = RUN;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end

        MDU_WAIT: begin
          if (mdu_done) begin
            // Result is captured into EXE/MEM this cycle with default enables.
            state_d    = RUN;
            wait_cnt_d = '0;
          end else begin
            pc_we      = 1'b0;
            if_id_we   = 1'b0;
            id_exe_we  = 1'b0;
            exe_mem_fl = 1'b1;
            if (wait_cnt_q == WAIT_LAST) begin
              state_d      = RUN;
              wait_cnt_d   = '0;
              timeout_fire = 1'b1;
            end else begin
              wait_cnt_d = wait_cnt_q + 1'b1;
            end
          end
        end

        default: state_d = RUN;
      endcase
    end
  end

  assign pc_write_en      = rst_n & pc_we;
  assign if_id_write_en   = rst_n & if_id_we;
  assign if_id_flush      = rst_n & if_id_fl;
  assign id_exe_write_en  = rst_n & id_exe_we;
  assign id_exe_flush     = rst_n & id_exe_fl;
  assign exe_mem_write_en = rst_n & exe_mem_we;
  assign exe_mem_flush    = rst_n & exe_mem_fl;
  assign mem_wb_write_en  = rst_n & mem_wb_we;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      mdu_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mdu_timeout <= timeout_fire;
      if (stat_clr) begin
        stall_cycles <= '0;
      end else if (!pc_write_en && stall_cycles != CNT_MAX) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// Directed testbench for pipeline_stall_controller (BRANCH_PENALTY=3,
// MDU_TIMEOUT=8, CNT_W=16). Inputs change 1 ns after a rising edge; the
// Mealy outputs are sampled on the falling edge, registered outputs 1 ns
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_use_hazard = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mdu_start = 1'b0;
  logic        mdu_done = 1'b0;
  logic        dmem_wait = 1'b0;
  logic        stat_clr = 1'b0;
  logic        pc_write_en, if_id_write_en, if_id_flush, id_exe_write_en;
  logic        id_exe_flush, exe_mem_write_en, exe_mem_flush, mem_wb_write_en;
  logic        mdu_timeout;
  logic [15:0] stall_cycles;

  int compared = 0;
  int mismatched = 0;

  // Control vector: {pc_we, if_id_we, if_id_fl, id_exe_we, id_exe_fl,
  //                  exe_mem_we, exe_mem_fl, mem_wb_we}
  localparam logic [7:0] C_DEF  = 8'b1101_0101;
  localparam logic [7:0] C_LU   = 8'b0001_1101;
  localparam logic [7:0] C_BR   = 8'b1111_1101;
  localparam logic [7:0] C_FL   = 8'b1111_0101;
  localparam logic [7:0] C_MW   = 8'b0000_0111;
  localparam logic [7:0] C_ZERO = 8'b0000_0000;

  logic [7:0] ctl;
  assign ctl = {pc_write_en, if_id_write_en, if_id_flush, id_exe_write_en,
                id_exe_flush, exe_mem_write_en, exe_mem_flush, mem_wb_write_en};

  always #5 clk = ~clk;

  pipeline_stall_controller #(
    .BRANCH_PENALTY(3),
    .MDU_TIMEOUT   (8),
    .CNT_W         (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_use_hazard (load_use_hazard),
    .branch_taken    (branch_taken),
    .mdu_start       (mdu_start),
    .mdu_done        (mdu_done),
    .dmem_wait       (dmem_wait),
    .stat_clr        (stat_clr),
    .pc_write_en     (pc_write_en),
    .if_id_write_en  (if_id_write_en),
    .if_id_flush     (if_id_flush),
    .id_exe_write_en (id_exe_write_en),
    .id_exe_flush    (id_exe_flush),
    .exe_mem_write_en(exe_mem_write_en),
    .exe_mem_flush   (exe_mem_flush),
    .mem_wb_write_en (mem_wb_write_en),
    .mdu_timeout     (mdu_timeout),
    .stall_cycles    (stall_cycles)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic lu, input logic br, input logic ms,
                        input logic md, input logic dw);
    load_use_hazard = lu;
    branch_taken    = br;
    mdu_start       = ms;
    mdu_done        = md;
    dmem_wait       = dw;
  endtask

  task automatic clear_stats;
    set_in(0, 0, 0, 0, 0);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
  endtask

  // Applies inputs for one cycle and compares the control vector mid-cycle.
  task automatic cycle_ctl(input string name, input logic lu, input logic br,
                           input logic ms, input logic md, input logic dw,
                           input logic [7:0] exp);
    set_in(lu, br, ms, md, dw);
    @(negedge clk);
    compared++;
    if (ctl !== exp) begin
      mismatched++;
      $display("FAIL %s: ctl got %b expected %b at %0t", name, ctl, exp, $time);
    end
    tick();
  endtask

  task automatic test_reset;
    set_in(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    compared++;
    if (ctl !== C_ZERO) begin
      mismatched++;
      $display("FAIL reset_ctl: got %b expected %b", ctl, C_ZERO);
    end
    compared++;
    if (stall_cycles !== 16'd0 || mdu_timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_regs: stall %0d tmo %b expected 0 0", stall_cycles, mdu_timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cycle_ctl("reset_release_default", 0, 0, 0, 0, 0, C_DEF);
    compared++;
    if (stall_cycles !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_release_stall: got %0d expected 0", stall_cycles);
    end
  endtask

  task automatic test_load_use;
    clear_stats();
    cycle_ctl("lu_stall", 1, 0, 0, 0, 0, C_LU);
    cycle_ctl("lu_after", 0, 0, 0, 0, 0, C_DEF);
    compared++;
    if (stall_cycles !== 16'd1) begin
      mismatched++;
      $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cycles);
    end
    // Two back-to-back hazard cycles give two bubbles.
    cycle_ctl("lu_b2b_0", 1, 0, 0, 0, 0, C_LU);
    cycle_ctl("lu_b2b_1", 1, 0, 0, 0, 0, C_LU);
    cycle_ctl("lu_b2b_end", 0, 0, 0, 0, 0, C_DEF);
    compared++;
    if (stall_cycles !== 16'd3) begin
      mismatched++;
      $display("FAIL lu_b2b_cnt: got %0d expected 3", stall_cycles);
    end
  endtask

  task automatic test_branch;
    clear_stats();
    // Branch with load-use and mdu_start in the same cycle: flushes only.
    cycle_ctl("br_cyc0", 1, 1, 1, 0, 0, C_BR);
    cycle_ctl("br_cyc1_ignore_lu", 1, 0, 0, 0, 0, C_FL);
    cycle_ctl("br_cyc2_ignore_ms", 0, 1, 1, 0, 0, C_FL);
    cycle_ctl("br_cyc3_default", 0, 0, 0, 0, 0, C_DEF);
    cycle_ctl("br_no_mdu_wait", 0, 0, 0, 0, 0, C_DEF);
    compared++;
    if (stall_cycles !== 16'd0) begin
      mismatched++;
      $display("FAIL br_stall_cnt: got %0d expected 0", stall_cycles);
    end
  endtask

  task automatic test_mdu_done;
    clear_stats();
    cycle_ctl("mdu_start", 0, 0, 1, 0, 0, C_DEF);
    cycle_ctl("mdu_hold1", 0, 0, 0, 0, 0, C_MW);
    cycle_ctl("mdu_hold2_ignore", 1, 1, 0, 0, 0, C_MW);
    cycle_ctl("mdu_hold3", 0, 0, 0, 0, 0, C_MW);
    cycle_ctl("mdu_hold4", 0, 0, 0, 0, 0, C_MW);
    cycle_ctl("mdu_done_cycle", 0, 0, 0, 1, 0, C_DEF);
    cycle_ctl("mdu_after", 0, 0, 0, 0, 0, C_DEF);
    compared++;
    if (stall_cycles !== 16'd4 || mdu_timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL mdu_done_regs: stall %0d tmo %b expected 4 0", stall_cycles, mdu_timeout);
    end
  endtask

  task automatic test_mdu_timeout;
    clear_stats();
    cycle_ctl("tmo_start", 0, 0, 1, 0, 0, C_DEF);
    for (int i = 0; i < 8; i++) cycle_ctl("tmo_hold", 0, 0, 0, 0, 0, C_MW);
    compared++;
    if (mdu_timeout !== 1'b1) begin
      mismatched++;
      $display("FAIL tmo_pulse: got %b expected 1", mdu_timeout);
    end
    cycle_ctl("tmo_back_run", 0, 0, 0, 0, 0, C_DEF);
    compared++;
    if (mdu_timeout !== 1'b0 || stall_cycles !== 16'd8) begin
      mismatched++;
      $display("FAIL tmo_after: tmo %b stall %0d expected 0 8", mdu_timeout, stall_cycles);
    end
    // Done on the last allowed cycle beats the timeout.
    clear_stats();
    cycle_ctl("tmo_race_start", 0, 0, 1, 0, 0, C_DEF);
    for (int i = 0; i < 7; i++) cycle_ctl("tmo_race_hold", 0, 0, 0, 0, 0, C_MW);
    cycle_ctl("tmo_race_done", 0, 0, 0, 1, 0, C_DEF);
    compared++;
    if (mdu_timeout !== 1'b0 || stall_cycles !== 16'd7) begin
      mismatched++;
      $display("FAIL tmo_race: tmo %b stall %0d expected 0 7", mdu_timeout, stall_cycles);
    end
  endtask

  task automatic test_dmem_wait;
    clear_stats();
    cycle_ctl("dw_br", 0, 1, 0, 0, 0, C_BR);
    for (int i = 0; i < 3; i++) cycle_ctl("dw_freeze", 1, 1, 1, 1, 1, C_ZERO);
    cycle_ctl("dw_flush_resume1", 0, 0, 0, 0, 0, C_FL);
    cycle_ctl("dw_flush_resume2", 0, 0, 0, 0, 0, C_FL);
    cycle_ctl("dw_flush_end", 0, 0, 0, 0, 0, C_DEF);
    compared++;
    if (stall_cycles !== 16'd3) begin
      mismatched++;
      $display("FAIL dw_stall_cnt: got %0d expected 3", stall_cycles);
    end
  endtask

  task automatic test_reset_mid;
    clear_stats();
    cycle_ctl("rm_start", 0, 0, 1, 0, 0, C_DEF);
    cycle_ctl("rm_hold1", 0, 0, 0, 0, 0, C_MW);
    set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++;
    if (ctl !== C_ZERO || stall_cycles !== 16'd0) begin
      mismatched++;
      $display("FAIL rm_async: ctl %b stall %0d expected %b 0", ctl, stall_cycles, C_ZERO);
    end
    #1;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) cycle_ctl("rm_run", 0, 0, 0, 0, 0, C_DEF);
    compared++;
    if (mdu_timeout !== 1'b0 || stall_cycles !== 16'd0) begin
      mismatched++;
      $display("FAIL rm_after: tmo %b stall %0d expected 0 0", mdu_timeout, stall_cycles);
    end
  endtask

  task automatic test_saturate;
    clear_stats();
    set_in(1, 0, 0, 0, 0);
    repeat (65535) @(posedge clk);
    #1;
    compared++;
    if (stall_cycles !== 16'hFFFF) begin
      mismatched++;
      $display("FAIL sat_reach: got %h expected ffff", stall_cycles);
    end
    tick();
    compared++;
    if (stall_cycles !== 16'hFFFF) begin
      mismatched++;
      $display("FAIL sat_hold: got %h expected ffff", stall_cycles);
    end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    set_in(0, 0, 0, 0, 0);
    compared++;
    if (stall_cycles !== 16'd0) begin
      mismatched++;
      $display("FAIL sat_clr: got %h expected 0", stall_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mdu_done();
    test_mdu_timeout();
    test_dmem_wait();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central sequencer for the 5-stage MIPS pipeline's stage-register enables and flushes.
- Merges four hold/flush sources into one consistent per-stage control set by fixed priority:
  - load-use hazard from the ID-stage hazard detector
  - taken-branch redirect from EXE
  - multi-cycle MUL/DIV unit (MDU) occupancy
  - data-memory wait
- Sits beside the hazard detector; drives PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.

Parameters:
- BRANCH_PENALTY, 2, total cycles IF/ID is flushed after a taken branch (1..7).
- MDU_TIMEOUT, 64, max MDU_WAIT cycles before forced exit (2..1023).
- CNT_W, 16, width of stall-cycle performance counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_use_hazard  input  1  ID instr depends on a load in EXE.
- branch_taken  input  1  EXE resolved a taken branch; PC target is valid this cycle.
- mdu_start  input  1  MDU op entering EXE this cycle.
- mdu_done  input  1  MDU result valid this cycle.
- dmem_wait  input  1  data memory not ready; MEM stage must hold.
- stat_clr  input  1  synchronous clear of stall_cycles.
- pc_write_en  output  1  PC register load enable.
- if_id_write_en  output  1  IF/ID register load enable.
- if_id_flush  output  1  IF/ID loads NOP.
- id_exe_write_en  output  1  ID/EXE register load enable.
- id_exe_flush  output  1  ID/EXE loads bubble.
- exe_mem_write_en  output  1  EXE/MEM register load enable.
- exe_mem_flush  output  1  EXE/MEM loads bubble.
- mem_wb_write_en  output  1  MEM/WB register load enable.
- mdu_timeout  output  1  one-cycle registered pulse on MDU timeout.
- stall_cycles  output  CNT_W  saturating count of cycles with pc_write_en=0.

Behaviour:
- States: RUN, FLUSH, MDU_WAIT. Reset state is RUN; flush_cnt=0, wait_cnt=0, stall_cycles=0, mdu_timeout=0.
- While rst_n=0, force all *_write_en=0 and all *_flush=0.
- Control outputs are combinational from state and current inputs (Mealy), so they act in the cycle the event is signalled.
- Default RUN with no events: all write_en=1, all flush=0.
- Priority, highest first, evaluated each cycle:
  1. dmem_wait, any state:
     - All write_en=0, all flush=0.
     - State, flush_cnt and wait_cnt hold; all other inputs ignored.
     - stall_cycles still counts.
  2. RUN, branch_taken:
     - pc_write_en=1, if_id_flush=1, id_exe_flush=1; other enables 1.
     - If BRANCH_PENALTY>1: go to FLUSH with flush_cnt=BRANCH_PENALTY-1.
     - Overrides load_use_hazard and mdu_start in the same cycle. The MDU op is squashed; the MDU must not be started.
  3. RUN, mdu_start:
     - All enables 1 this cycle.
     - Next state MDU_WAIT, wait_cnt=0.
  4. RUN, load_use_hazard:
     - pc_write_en=0, if_id_write_en=0, id_exe_flush=1; other enables 1.
     - Exactly one bubble per asserted cycle; stays in RUN.
- FLUSH:
  - pc_write_en=1, if_id_flush=1, all other enables 1.
  - flush_cnt decrements; return to RUN when it reaches 1 on this cycle.
  - branch_taken, mdu_start and load_use_hazard are ignored.
- MDU_WAIT:
  - pc_write_en=0, if_id_write_en=0, id_exe_write_en=0, exe_mem_flush=1; mem_wb_write_en=1.
  - wait_cnt increments.
  - mdu_done: this cycle outputs are RUN-default (result captured into EXE/MEM); next state RUN.
  - wait_cnt==MDU_TIMEOUT-1 without mdu_done: next state RUN, mdu_timeout=1 next cycle only.
  - mdu_done and timeout in the same cycle: done wins, no timeout pulse.
  - branch_taken and load_use_hazard are ignored.
- stall_cycles:
  - +1 on each clk edge where rst_n=1 and pc_write_en=0.
  - Saturates at 2^CNT_W-1.
  - stat_clr has priority over increment and zeroes it.
- Asynchronous reset mid-operation (any state): immediate return to reset values; no partial flush resumes.

Test Plan:
- Reset release, no events -> all write_en=1, flush=0, stall_cycles=0, state RUN.
- load_use_hazard high 1 cycle -> that cycle pc_write_en=0, if_id_write_en=0, id_exe_flush=1; next cycle defaults; stall_cycles=1.
- branch_taken with BRANCH_PENALTY=3 -> cycle0 if_id_flush=1, id_exe_flush=1; cycles 1-2 if_id_flush=1 only; cycle3 defaults. branch_taken+load_use same cycle -> no stall, flushes only.
- mdu_start, mdu_done 5 cycles later -> 4 cycles of pc_write_en=0 / exe_mem_flush=1, done cycle defaults, stall_cycles=4.
- mdu_start, no done, MDU_TIMEOUT=8 -> 8 hold cycles, mdu_timeout pulses 1 cycle, back to RUN.
- dmem_wait 3 cycles during FLUSH, then rst_n low mid-MDU_WAIT -> all enables 0 and flush_cnt held for 3 cycles, then FLUSH resumes; reset immediately forces RUN and stall_cycles=0. stall_cycles at 0xFFFF with stall -> stays 0xFFFF; stat_clr -> 0.
